ondra_boot_ctrl: RTL and testbench

//  Power-up and reset sequencer that runs ahead of Ondra_SPO186_core.
//  - Waits for PLL lock, then reads the scandoubler settings byte from SRAM.
//  - Owns the SRAM address/WE lines until the byte is read, then hands the bus to the core.
//  - Holds the core in reset for a fixed time after hand-over.
//  - Debounces the SERVICE button; each press toggles ROM version bit 0 and re-resets the core.

---
 rtl/ondra_boot_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ondra_boot_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ondra_boot_ctrl.sv
// Power-up sequencer ahead of the Ondra core: waits for PLL lock, reads the scandoubler
// settings byte from SRAM, then hands the SRAM bus to the core and releases its reset.
module ondra_boot_ctrl #(
    parameter logic [18:0] CFG_ADDR        = 19'h08FD5,
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned READ_WAIT       = 2,
    parameter int unsigned RESET_HOLD      = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic [7:0]  CFG_DEFAULT     = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pll_locked,
    input  logic        service_n,
    input  logic [7:0]  sram_data_in,
    input  logic [18:0] core_sram_addr,
    input  logic        core_sram_we,
    output logic [18:0] sram_addr,
    output logic        sram_we,
    output logic [7:0]  scandblr_reg,
    output logic        cfg_valid,
    output logic [1:0]  rom_version,
    output logic        core_reset
);

    localparam int unsigned MAX_SR  = (SETTLE_CYCLES > READ_WAIT) ? SETTLE_CYCLES : READ_WAIT;
    localparam int unsigned CNT_MAX = (MAX_SR > RESET_HOLD) ? MAX_SR : RESET_HOLD;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] READ_LAST   = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        ADDR,
        SAMPLE,
        HOLD,
        RUN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]    rom_n;
    logic          valid_n;
    logic          load_cfg;

    logic          lock_meta, lock_sync;
    logic          svc_meta, svc_sync, svc_stable;
    logic [DW-1:0] db_cnt;
    logic          press;
    logic          core_owns;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            svc_meta  <= 1'b1;
            svc_sync  <= 1'b1;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
            svc_meta  <= service_n;
            svc_sync  <= svc_meta;
        end
    end

    // Counter runs only while the input disagrees with the stable level; any agreeing sample restarts it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            svc_stable <= 1'b1;
            db_cnt     <= '0;
        end else if (svc_sync == svc_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            svc_stable <= svc_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign press   = (svc_sync != svc_stable) && (db_cnt == DB_LAST) && !svc_sync;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt_inc;
        rom_n    = rom_version;
        valid_n  = cfg_valid;
        load_cfg = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_n = '0;
                if (lock_sync) state_n = SETTLE;
            end
            SETTLE: if (cnt == SETTLE_LAST) begin
                state_n = ADDR;
                cnt_n   = '0;
            end
            ADDR: if (cnt == READ_LAST) begin
                state_n = SAMPLE;
                cnt_n   = '0;
            end
            SAMPLE: begin
                load_cfg = lock_sync;
                valid_n  = 1'b1;
                state_n  = HOLD;
                cnt_n    = '0;
            end
            HOLD: if (cnt == HOLD_LAST) begin
                state_n = RUN;
                cnt_n   = '0;
            end
            RUN:     cnt_n = '0;
            default: state_n = WAIT_LOCK;
        endcase

        if (press) begin
            rom_n[0] = ~rom_version[0];
            if (state == HOLD || state == RUN) begin
                state_n = HOLD;
                cnt_n   = '0;
            end
        end

        // Lock loss overrides everything above, including a press restart.
        if (!lock_sync && state != WAIT_LOCK) begin
            state_n  = WAIT_LOCK;
            cnt_n    = '0;
            valid_n  = 1'b0;
            load_cfg = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            scandblr_reg <= CFG_DEFAULT;
            cfg_valid    <= 1'b0;
            rom_version  <= 2'b01;
            core_reset   <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cfg_valid   <= valid_n;
            rom_version <= rom_n;
            core_reset  <= (state_n != RUN);
            if (load_cfg) scandblr_reg <= sram_data_in;
        end
    end

    assign core_owns = !reset && (state == HOLD || state == RUN);
    assign sram_addr = core_owns ? core_sram_addr : CFG_ADDR;
    assign sram_we   = core_owns && core_sram_we;

endmodule

// File: tb/tb_ondra_boot_ctrl.sv
// Directed plus randomized bench for ondra_boot_ctrl against a timeline-based reference model.
module tb_ondra_boot_ctrl;

    localparam logic [18:0] CFG = 19'h08FD5;
    localparam int S   = 16;
    localparam int R   = 2;
    localparam int H   = 1024;
    localparam int DEB = 8;

    logic        clk = 1'b0;
    logic        reset, pll_locked, service_n;
    logic [7:0]  sram_data_in;
    logic [18:0] core_sram_addr;
    logic        core_sram_we;
    logic [18:0] sram_addr;
    logic        sram_we;
    logic [7:0]  scandblr_reg;
    logic        cfg_valid;
    logic [1:0]  rom_version;
    logic        core_reset;

    logic [7:0]  cfg_byte, junk;
    int          checks = 0;
    int          errors = 0;
    int          hold_cnt;

    // Reference model: seq = position in the boot timeline (-1 idle), hold = HOLD cycles left.
    bit [1:0]    m_lp, m_sp;
    bit          m_stable, m_core, m_valid, m_rst_out;
    int          m_diff, m_seq, m_hold;
    logic [7:0]  m_cfg;
    logic [1:0]  m_rom;

    always #5 clk = ~clk;

    always_comb sram_data_in = (sram_addr == CFG) ? cfg_byte : junk;

    ondra_boot_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk_sys(clk), .reset(reset), .pll_locked(pll_locked), .service_n(service_n),
        .sram_data_in(sram_data_in), .core_sram_addr(core_sram_addr), .core_sram_we(core_sram_we),
        .sram_addr(sram_addr), .sram_we(sram_we), .scandblr_reg(scandblr_reg),
        .cfg_valid(cfg_valid), .rom_version(rom_version), .core_reset(core_reset)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lp = 2'b00; m_sp = 2'b11; m_stable = 1'b1; m_diff = 0;
        m_seq = -1; m_hold = 0; m_core = 1'b0; m_valid = 1'b0;
        m_cfg = 8'h00; m_rom = 2'b01; m_rst_out = 1'b1;
    endtask

    task automatic model_step();
        bit ls, s, press, lost, core_n, valid_n;
        int seq_n, hold_n;
        logic [7:0] cfg_n;
        if (reset) begin
            model_reset();
        end else begin
            ls = m_lp[1]; s = m_sp[1]; press = 1'b0;
            if (s != m_stable) begin
                if (m_diff + 1 == DEB) begin
                    m_stable = s; m_diff = 0; press = (s == 1'b0);
                end else m_diff++;
            end else m_diff = 0;
            lost = !ls && (m_core || m_seq >= 0);
            seq_n = m_seq; hold_n = m_hold; core_n = m_core; valid_n = m_valid; cfg_n = m_cfg;
            if (!m_core) begin
                if (m_seq < 0) begin
                    if (ls) seq_n = 0;
                end else if (m_seq < S + R) seq_n = m_seq + 1;
                else begin
                    cfg_n = cfg_byte; valid_n = 1'b1; core_n = 1'b1; hold_n = H; seq_n = -1;
                end
            end else if (m_hold > 0) hold_n = m_hold - 1;
            if (press) begin
                m_rom[0] = ~m_rom[0];
                if (m_core) hold_n = H;
            end
            if (lost) begin
                core_n = 1'b0; seq_n = -1; valid_n = 1'b0; cfg_n = m_cfg; hold_n = 0;
            end
            m_seq = seq_n; m_hold = hold_n; m_core = core_n; m_valid = valid_n; m_cfg = cfg_n;
            m_rst_out = !(core_n && hold_n == 0);
            m_lp = {m_lp[0], pll_locked};
            m_sp = {m_sp[0], service_n};
        end
    endtask

    task automatic tick();
        logic [18:0] ea;
        logic        ew;
        model_step();
        @(posedge clk);
        #1;
        ea = (m_core && !reset) ? core_sram_addr : CFG;
        ew = m_core && !reset && core_sram_we;
        check("core_reset", 32'(core_reset), 32'(m_rst_out));
        check("cfg_valid", 32'(cfg_valid), 32'(m_valid));
        check("scandblr_reg", 32'(scandblr_reg), 32'(m_cfg));
        check("rom_version", 32'(rom_version), 32'(m_rom));
        check("sram_addr", 32'(sram_addr), 32'(ea));
        check("sram_we", 32'(sram_we), 32'(ew));
        core_sram_addr = 19'($urandom);
        core_sram_we   = 1'($urandom);
        junk           = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset), 32'(1));
        check({tag, "_cfg_valid"}, 32'(cfg_valid), 32'(0));
        check({tag, "_scandblr"}, 32'(scandblr_reg), 32'(8'h00));
        check({tag, "_rom"}, 32'(rom_version), 32'(2'b01));
        check({tag, "_addr"}, 32'(sram_addr), 32'(CFG));
        check({tag, "_we"}, 32'(sram_we), 32'(0));
    endtask

    initial begin
        reset = 1'b1; pll_locked = 1'b0; service_n = 1'b1;
        cfg_byte = 8'hFE; junk = 8'h5A; core_sram_addr = '0; core_sram_we = 1'b1;
        model_reset();
        repeat (3) tick();
        check_reset_vals("por");
        reset = 1'b0;

        // No lock: boot keeps the bus and the core in reset.
        repeat (1000) tick();
        check("nolock_valid", 32'(cfg_valid), 32'(0));
        check("nolock_addr", 32'(sram_addr), 32'(CFG));

        // Lock and full boot; core_reset overlaps cfg_valid for exactly H cycles.
        repeat (10) tick();
        pll_locked = 1'b1;
        hold_cnt = 0;
        repeat (1100) begin
            tick();
            if (cfg_valid && core_reset) hold_cnt++;
        end
        check("boot_hold_len", 32'(hold_cnt), 32'(H));
        check("boot_cfg", 32'(scandblr_reg), 32'(8'hFE));
        check("boot_valid", 32'(cfg_valid), 32'(1));
        check("boot_run", 32'(core_reset), 32'(0));

        // One-cycle lock loss, byte changed before the re-read.
        cfg_byte = 8'h01;
        pll_locked = 1'b0; tick();
        pll_locked = 1'b1; repeat (3) tick();
        check("relock_reset", 32'(core_reset), 32'(1));
        check("relock_valid", 32'(cfg_valid), 32'(0));
        repeat (1100) tick();
        check("relock_cfg", 32'(scandblr_reg), 32'(8'h01));
        check("relock_run", 32'(core_reset), 32'(0));

        // Short press is rejected.
        service_n = 1'b0; repeat (5) tick();
        service_n = 1'b1; repeat (20) tick();
        check("short_rom", 32'(rom_version), 32'(2'b01));
        check("short_run", 32'(core_reset), 32'(0));

        // Long press: toggle and re-hold the core.
        hold_cnt = 0;
        service_n = 1'b0;
        repeat (20) begin tick(); if (core_reset) hold_cnt++; end
        service_n = 1'b1;
        repeat (1100) begin tick(); if (core_reset) hold_cnt++; end
        check("press1_hold_len", 32'(hold_cnt), 32'(H));
        check("press1_rom", 32'(rom_version), 32'(2'b00));
        check("press1_cfg", 32'(scandblr_reg), 32'(8'h01));
        service_n = 1'b0; repeat (20) tick();
        service_n = 1'b1; repeat (1100) tick();
        check("press2_rom", 32'(rom_version), 32'(2'b01));

        // Press landing on the last HOLD cycle keeps the core in reset.
        service_n = 1'b0; repeat (12) tick();
        service_n = 1'b1;
        for (int i = 0; i < 2000 && !(m_core && m_hold == DEB + 2); i++) tick();
        service_n = 1'b0; repeat (DEB + 1) tick();
        check("lasthold_reset", 32'(core_reset), 32'(1));
        service_n = 1'b1; repeat (1100) tick();

        // Reset during HOLD, then during ADDR.
        service_n = 1'b0; repeat (12) tick();
        service_n = 1'b1; repeat (5) tick();
        reset = 1'b1; tick();
        check_reset_vals("rst_hold");
        reset = 1'b0;
        repeat (1100) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 100 && m_seq < S; i++) tick();
        reset = 1'b1; tick();
        check_reset_vals("rst_addr");
        reset = 1'b0;
        repeat (1100) tick();
        check("rerun_run", 32'(core_reset), 32'(0));
        check("rerun_valid", 32'(cfg_valid), 32'(1));

        // Randomized mix of lock drops, presses, byte changes and resets.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    pll_locked = 1'b0; repeat ($urandom_range(1, 4)) tick(); pll_locked = 1'b1;
                end
                1: begin
                    service_n = 1'b0; repeat ($urandom_range(1, 20)) tick(); service_n = 1'b1;
                end
                2: repeat ($urandom_range(1, 1100)) tick();
                3: cfg_byte = 8'($urandom);
                default: begin
                    reset = 1'b1; repeat ($urandom_range(1, 3)) tick(); reset = 1'b0;
                end
            endcase
            repeat ($urandom_range(0, 50)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
